// File: rtl/axi_stream_slave_tb.sv
// AXI4-Stream capture slave: buffers {tlast, tdata} beats in a FIFO drained through rd_en.
// Optional AXIS_SLAVE_BACKPRESSURE_EN drops tready one cycle in four to exercise master stalls.
module axi_stream_slave_tb #(
    parameter int unsigned C_S_AXIS_TDATA_WIDTH = 32,
    parameter int unsigned FIFO_SIZE            = 2048
) (
    input  logic                                s00_axis_aclk,
    input  logic                                s00_axis_areset,
    input  logic                                s00_axis_tvalid,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0]     s00_axis_tdata,
    input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0]   s00_axis_tstrb,
    input  logic                                s00_axis_tlast,
    output logic                                s00_axis_tready,
    input  logic                                rd_en,
    output logic [C_S_AXIS_TDATA_WIDTH-1:0]     rd_data,
    output logic                                rd_last,
    output logic                                rd_valid,
    output logic [$clog2(FIFO_SIZE):0]          level,
    output logic [31:0]                         pkt_count,
    output logic                                strb_err
);

    localparam int unsigned DW = C_S_AXIS_TDATA_WIDTH;
    localparam int unsigned AW = $clog2(FIFO_SIZE);
    localparam int unsigned LW = AW + 1;

    logic [DW:0]    r_mem [FIFO_SIZE];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [LW-1:0]  r_level;
    logic           r_rst_done;
    logic [31:0]    r_pkt_count;
    logic           r_strb_err;
    logic           r_rd_valid;
    logic [DW-1:0]  r_rd_data;
    logic           r_rd_last;

    logic           w_not_full;
    logic           w_tready;
    logic           w_accept;
    logic           w_pop;

    assign w_not_full = (r_level < LW'(FIFO_SIZE));

`ifdef AXIS_SLAVE_BACKPRESSURE_EN
    logic [1:0] r_thr_cnt;

    // Throttle counter starts once the slave is out of reset
    always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
        if (s00_axis_areset) begin
            r_thr_cnt <= 2'd0;
        end else if (r_rst_done) begin
            r_thr_cnt <= r_thr_cnt + 2'd1;
        end
    end

    assign w_tready = r_rst_done && w_not_full && (r_thr_cnt != 2'd3);
`else
    assign w_tready = r_rst_done && w_not_full;
`endif

    assign w_accept = s00_axis_tvalid && w_tready;
    assign w_pop    = rd_en && (r_level != '0);

    // r_rst_done keeps tready low until the first edge after reset release
    always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
        if (s00_axis_areset) begin
            r_rst_done  <= 1'b0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_pkt_count <= 32'd0;
            r_strb_err  <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_rd_data   <= '0;
            r_rd_last   <= 1'b0;
        end else begin
            r_rst_done <= 1'b1;
            r_rd_valid <= w_pop;
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
                if (s00_axis_tlast) begin
                    r_pkt_count <= r_pkt_count + 32'd1;
                end
                if (s00_axis_tstrb != '1) begin
                    r_strb_err <= 1'b1;
                end
            end
            if (w_pop) begin
                r_rd_ptr  <= r_rd_ptr + AW'(1);
                r_rd_data <= r_mem[r_rd_ptr][DW-1:0];
                r_rd_last <= r_mem[r_rd_ptr][DW];
            end
            if (w_accept && !w_pop) begin
                r_level <= r_level + LW'(1);
            end else if (!w_accept && w_pop) begin
                r_level <= r_level - LW'(1);
            end
        end
    end

    // Buffer storage is deliberately not reset
    always_ff @(posedge s00_axis_aclk) begin
        if (w_accept) begin
            r_mem[r_wr_ptr] <= {s00_axis_tlast, s00_axis_tdata};
        end
    end

    assign s00_axis_tready = w_tready;
    assign rd_data         = r_rd_data;
    assign rd_last         = r_rd_last;
    assign rd_valid        = r_rd_valid;
    assign level           = r_level;
    assign pkt_count       = r_pkt_count;
    assign strb_err        = r_strb_err;

endmodule

// File: tb/tb_axi_stream_slave_tb.sv
// Scoreboard bench for axi_stream_slave_tb (FIFO_SIZE=4); AXIS_SLAVE_BACKPRESSURE_EN adds the throttle test.
module tb_axi_stream_slave_tb;

    localparam int unsigned DW = 32;
    localparam int unsigned FS = 4;
    localparam int unsigned LW = $clog2(FS) + 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            tvalid;
    logic [DW-1:0]   tdata;
    logic [DW/8-1:0] tstrb;
    logic            tlast;
    logic            tready;
    logic            rd_en;
    logic [DW-1:0]   rd_data;
    logic            rd_last;
    logic            rd_valid;
    logic [LW-1:0]   level;
    logic [31:0]     pkt_count;
    logic            strb_err;

    logic [DW:0]     sb [$];
    int              n_tests = 0;
    int              n_fail  = 0;
    logic            obs_tready;

    axi_stream_slave_tb #(
        .C_S_AXIS_TDATA_WIDTH(DW),
        .FIFO_SIZE           (FS)
    ) dut (
        .s00_axis_aclk  (clk),
        .s00_axis_areset(rst),
        .s00_axis_tvalid(tvalid),
        .s00_axis_tdata (tdata),
        .s00_axis_tstrb (tstrb),
        .s00_axis_tlast (tlast),
        .s00_axis_tready(tready),
        .rd_en          (rd_en),
        .rd_data        (rd_data),
        .rd_last        (rd_last),
        .rd_valid       (rd_valid),
        .level          (level),
        .pkt_count      (pkt_count),
        .strb_err       (strb_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    // One clock: drive on negedge, note tready before the edge, sample 1ns after the edge
    task automatic tick(input logic v, input logic [DW-1:0] d, input logic [DW/8-1:0] s,
                        input logic l, input logic re);
        @(negedge clk);
        tvalid = v; tdata = d; tstrb = s; tlast = l; rd_en = re;
        #1 obs_tready = tready;
        @(posedge clk);
        #1;
        if (v && obs_tready) sb.push_back({l, d});
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic [DW/8-1:0] s, input logic l,
                             output int ncyc);
        bit done = 1'b0;
        ncyc = 0;
        for (int i = 0; i < 8 && !done; i++) begin
            tick(1'b1, d, s, l, 1'b0);
            ncyc++;
            done = obs_tready;
        end
        if (!done) begin
            n_tests++; n_fail++;
            $display("FAIL send_beat: tready stayed 0 for data %h, required acceptance", d);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; tvalid = 1'b0; tdata = '0; tstrb = '1; tlast = 1'b0; rd_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++; if (tready !== 1'b0) begin n_fail++; $display("FAIL rst_tready: got %b want 0", tready); end
        n_tests++; if (level !== '0 || pkt_count !== 32'd0) begin n_fail++;
            $display("FAIL rst_counts: level %0d pkt %0d want 0 0", level, pkt_count); end
        n_tests++; if (strb_err !== 1'b0 || rd_valid !== 1'b0) begin n_fail++;
            $display("FAIL rst_flags: strb_err %b rd_valid %b want 0 0", strb_err, rd_valid); end
        n_tests++; if (rd_data !== '0 || rd_last !== 1'b0) begin n_fail++;
            $display("FAIL rst_rd: rd_data %h rd_last %b want 0 0", rd_data, rd_last); end
        @(negedge clk); rst = 1'b0;
        #1;
        n_tests++; if (tready !== 1'b0) begin n_fail++; $display("FAIL rel_tready: got %b before edge want 0", tready); end
        @(posedge clk); #1;
        n_tests++; if (tready !== 1'b1) begin n_fail++; $display("FAIL up_tready: got %b after edge want 1", tready); end
        sb.delete();
    endtask

    task automatic test_order();
        int nc;
        logic [DW:0] e;
        for (int i = 1; i <= 4; i++) send_beat(DW'(i), '1, (i == 4), nc);
        n_tests++; if (level !== LW'(4) || pkt_count !== 32'd1) begin n_fail++;
            $display("FAIL order_fill: level %0d pkt %0d want 4 1", level, pkt_count); end
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, '0, '1, 1'b0, 1'b1);
            n_tests++;
            if (sb.size() == 0) begin n_fail++; $display("FAIL order_pop: scoreboard empty, rd_data %h", rd_data); end
            else begin
                e = sb.pop_front();
                if (rd_valid !== 1'b1 || rd_data !== e[DW-1:0] || rd_last !== e[DW]) begin n_fail++;
                    $display("FAIL order_pop: got v%b %h l%b want v1 %h l%b", rd_valid, rd_data, rd_last, e[DW-1:0], e[DW]); end
            end
        end
        n_tests++; if (level !== '0) begin n_fail++; $display("FAIL order_drain: level %0d want 0", level); end
    endtask

    task automatic test_empty_read();
        tick(1'b0, '0, '1, 1'b0, 1'b1);
        tick(1'b0, '0, '1, 1'b0, 1'b0);
        n_tests++; if (rd_valid !== 1'b0 || level !== '0) begin n_fail++;
            $display("FAIL empty_rd: rd_valid %b level %0d want 0 0", rd_valid, level); end
        n_tests++; if (rd_data !== 32'd4 || rd_last !== 1'b1) begin n_fail++;
            $display("FAIL empty_hold: rd_data %h rd_last %b want 00000004 1", rd_data, rd_last); end
    endtask

    task automatic test_full();
        int nc;
        logic [DW:0] e;
        for (int i = 10; i <= 13; i++) send_beat(DW'(i), '1, 1'b0, nc);
        tick(1'b1, 32'd14, '1, 1'b0, 1'b0);
        n_tests++; if (obs_tready !== 1'b0 || level !== LW'(4)) begin n_fail++;
            $display("FAIL full_hold: tready %b level %0d want 0 4", obs_tready, level); end
        tick(1'b1, 32'd14, '1, 1'b0, 1'b1);
        n_tests++; if (obs_tready !== 1'b0) begin n_fail++;
            $display("FAIL full_pop_same: tready %b during pop want 0", obs_tready); end
        n_tests++;
        if (sb.size() == 0) begin n_fail++; $display("FAIL full_pop: scoreboard empty, rd_data %h", rd_data); end
        else begin
            e = sb.pop_front();
            if (rd_valid !== 1'b1 || rd_data !== e[DW-1:0] || level !== LW'(3)) begin n_fail++;
                $display("FAIL full_pop: got v%b %h lvl %0d want v1 %h lvl 3", rd_valid, rd_data, level, e[DW-1:0]); end
        end
        send_beat(32'd14, '1, 1'b0, nc);
        n_tests++; if (level !== LW'(4)) begin n_fail++; $display("FAIL full_refill: level %0d want 4", level); end
`ifndef AXIS_SLAVE_BACKPRESSURE_EN
        n_tests++; if (nc != 1) begin n_fail++; $display("FAIL full_next: accepted after %0d cycles want 1", nc); end
`endif
        tick(1'b1, 32'd15, '1, 1'b1, 1'b0);
        n_tests++; if (obs_tready !== 1'b0 || level !== LW'(4) || pkt_count !== 32'd1) begin n_fail++;
            $display("FAIL full_refuse: tready %b level %0d pkt %0d want 0 4 1", obs_tready, level, pkt_count); end
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, '0, '1, 1'b0, 1'b1);
            n_tests++;
            if (sb.size() == 0) begin n_fail++; $display("FAIL full_drain: scoreboard empty, rd_data %h", rd_data); end
            else begin
                e = sb.pop_front();
                if (rd_valid !== 1'b1 || rd_data !== e[DW-1:0] || rd_last !== e[DW]) begin n_fail++;
                    $display("FAIL full_drain: got v%b %h l%b want v1 %h l%b", rd_valid, rd_data, rd_last, e[DW-1:0], e[DW]); end
            end
        end
    endtask

    task automatic test_strb();
        int nc;
        logic [DW:0] e;
        n_tests++; if (strb_err !== 1'b0) begin n_fail++; $display("FAIL strb_pre: strb_err %b want 0", strb_err); end
        send_beat(32'hDEADBEEF, 4'b0111, 1'b0, nc);
        n_tests++; if (strb_err !== 1'b1 || level !== LW'(1)) begin n_fail++;
            $display("FAIL strb_set: strb_err %b level %0d want 1 1", strb_err, level); end
        tick(1'b0, '0, '1, 1'b0, 1'b1);
        n_tests++;
        if (sb.size() == 0) begin n_fail++; $display("FAIL strb_pop: scoreboard empty, rd_data %h", rd_data); end
        else begin
            e = sb.pop_front();
            if (rd_valid !== 1'b1 || rd_data !== e[DW-1:0]) begin n_fail++;
                $display("FAIL strb_pop: got v%b %h want v1 %h", rd_valid, rd_data, e[DW-1:0]); end
        end
        repeat (3) tick(1'b0, '0, '1, 1'b0, 1'b0);
        n_tests++; if (strb_err !== 1'b1) begin n_fail++; $display("FAIL strb_sticky: strb_err %b want 1", strb_err); end
    endtask

    task automatic test_reset_mid();
        int nc;
        logic [DW:0] e;
        send_beat(32'hA0, '1, 1'b0, nc);
        send_beat(32'hA1, '1, 1'b0, nc);
        @(negedge clk); rst = 1'b1; tvalid = 1'b1; tdata = 32'hA2; tlast = 1'b1;
        #1;
        n_tests++; if (level !== '0 || pkt_count !== 32'd0 || strb_err !== 1'b0) begin n_fail++;
            $display("FAIL mid_rst: level %0d pkt %0d strb_err %b want 0 0 0", level, pkt_count, strb_err); end
        n_tests++; if (tready !== 1'b0) begin n_fail++; $display("FAIL mid_tready: got %b want 0", tready); end
        repeat (2) @(posedge clk);
        #1;
        n_tests++; if (tready !== 1'b0 || level !== '0) begin n_fail++;
            $display("FAIL mid_hold: tready %b level %0d want 0 0", tready, level); end
        sb.delete();
        @(negedge clk); rst = 1'b0; tvalid = 1'b0; tlast = 1'b0;
        tick(1'b0, '0, '1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) send_beat(32'h100 + DW'(i), '1, (i == 2), nc);
        n_tests++; if (pkt_count !== 32'd1 || level !== LW'(3)) begin n_fail++;
            $display("FAIL mid_pkt: pkt %0d level %0d want 1 3", pkt_count, level); end
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, '0, '1, 1'b0, 1'b1);
            n_tests++;
            if (sb.size() == 0) begin n_fail++; $display("FAIL mid_pop: scoreboard empty, rd_data %h", rd_data); end
            else begin
                e = sb.pop_front();
                if (rd_valid !== 1'b1 || rd_data !== e[DW-1:0] || rd_last !== e[DW]) begin n_fail++;
                    $display("FAIL mid_pop: got v%b %h l%b want v1 %h l%b", rd_valid, rd_data, rd_last, e[DW-1:0], e[DW]); end
            end
        end
    endtask

`ifdef AXIS_SLAVE_BACKPRESSURE_EN
    task automatic test_backpressure();
        int acc = 0;
        logic [DW:0] e;
        @(negedge clk); rst = 1'b1; tvalid = 1'b0; rd_en = 1'b0;
        @(negedge clk); rst = 1'b0;
        sb.delete();
        tick(1'b0, '0, '1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, 32'h200 + DW'(acc), '1, (acc == 5), 1'b1);
            n_tests++; if (obs_tready !== ((i % 4) != 3)) begin n_fail++;
                $display("FAIL bp_tready: cycle %0d got %b want %b", i, obs_tready, ((i % 4) != 3)); end
            if (obs_tready) acc++;
            if (rd_valid) begin
                e = sb.pop_front();
                n_tests++; if (rd_data !== e[DW-1:0]) begin n_fail++;
                    $display("FAIL bp_order: got %h want %h", rd_data, e[DW-1:0]); end
            end
        end
        n_tests++; if (acc != 6 || pkt_count !== 32'd1) begin n_fail++;
            $display("FAIL bp_count: accepted %0d pkt %0d want 6 1", acc, pkt_count); end
        for (int i = 0; i < 8; i++) begin
            tick(1'b0, '0, '1, 1'b0, 1'b1);
            if (rd_valid) begin
                e = sb.pop_front();
                n_tests++; if (rd_data !== e[DW-1:0] || rd_last !== e[DW]) begin n_fail++;
                    $display("FAIL bp_drain: got %h l%b want %h l%b", rd_data, rd_last, e[DW-1:0], e[DW]); end
            end
        end
        n_tests++; if (sb.size() != 0 || level !== '0) begin n_fail++;
            $display("FAIL bp_empty: %0d left in scoreboard, level %0d want 0 0", sb.size(), level); end
    endtask
`endif

    initial begin
        rst = 1'b1; tvalid = 1'b0; tdata = '0; tstrb = '1; tlast = 1'b0; rd_en = 1'b0;
        test_reset();
        test_order();
        test_empty_read();
        test_full();
        test_strb();
        test_reset_mid();
`ifdef AXIS_SLAVE_BACKPRESSURE_EN
        test_backpressure();
`endif
        tick(1'b0, '0, '1, 1'b0, 1'b0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
